// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of an asynchronous PWM input and
// converts them to an 8-bit duty code with a bit-serial restoring divider.
module pwm_capture #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             en,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [7:0]       duty8,
  output logic             meas_valid,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW
  } state_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_STEP,
    DIV_PUB
  } div_state_t;

  state_t     state, state_nx;
  div_state_t div_state;

  logic sync1, s, s_d;
  logic rise, fall;

  logic [CNT_W-1:0] pcnt, hcnt;
  logic             cnt_clear, cnt_start, cnt_run, hcnt_inc;
  logic             close, to_fire, to_hi;

  logic [CNT_W+7:0] num_w;
  logic [CNT_W-1:0] cap_h, cap_p, rem;
  logic [7:0]       num_lo, quo;
  logic [2:0]       step;
  logic [CNT_W:0]   trial;
  logic [CNT_W-1:0] diff;
  logic             sub_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // ARM also runs the period counter so that a level that never toggles
  // still times out; the stuck polarity then follows the sampled level.
  always_comb begin
    state_nx  = state;
    cnt_clear = 1'b0;
    cnt_start = 1'b0;
    cnt_run   = 1'b0;
    hcnt_inc  = 1'b0;
    close     = 1'b0;
    to_fire   = 1'b0;
    to_hi     = 1'b0;
    if (!en) begin
      state_nx  = S_IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        S_IDLE: state_nx = S_ARM;
        S_ARM: begin
          if (rise) begin
            cnt_start = 1'b1;
            state_nx  = S_HIGH;
          end else if (pcnt == CNT_MAX) begin
            to_fire = 1'b1;
            to_hi   = s;
          end else begin
            cnt_run = 1'b1;
          end
        end
        S_HIGH: begin
          if (pcnt == CNT_MAX) begin
            to_fire  = 1'b1;
            to_hi    = 1'b1;
            state_nx = S_ARM;
          end else begin
            cnt_run  = 1'b1;
            hcnt_inc = s;
            if (fall) state_nx = S_LOW;
          end
        end
        S_LOW: begin
          if (rise) begin
            close     = 1'b1;
            cnt_start = 1'b1;
            state_nx  = S_HIGH;
          end else if (pcnt == CNT_MAX) begin
            to_fire  = 1'b1;
            to_hi    = 1'b0;
            state_nx = S_ARM;
          end else begin
            cnt_run  = 1'b1;
            hcnt_inc = s;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (cnt_clear) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (cnt_start) begin
      pcnt <= CNT_ONE;
      hcnt <= CNT_ONE;
    end else if (to_fire) begin
      pcnt <= CNT_ONE;
      hcnt <= '0;
    end else if (cnt_run) begin
      pcnt <= pcnt + CNT_ONE;
      if (hcnt_inc) hcnt <= hcnt + CNT_ONE;
    end
  end

  // The upper CNT_W bits of hcnt*256-1 are hcnt-1 < pcnt, so the partial
  // remainder starts below the divisor and 8 steps yield the whole quotient.
  assign num_w  = {hcnt, 8'h00} - (CNT_W + 8)'(1);
  assign trial  = {rem, num_lo[7]};
  assign sub_ok = (trial >= {1'b0, cap_p});
  assign diff   = trial[CNT_W-1:0] - cap_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_state <= DIV_IDLE;
      cap_h     <= '0;
      cap_p     <= '0;
      rem       <= '0;
      num_lo    <= '0;
      quo       <= '0;
      step      <= '0;
    end else if (!en) begin
      div_state <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (close) begin
            cap_h     <= hcnt;
            cap_p     <= pcnt;
            rem       <= num_w[CNT_W+7:8];
            num_lo    <= num_w[7:0];
            quo       <= '0;
            step      <= '0;
            div_state <= DIV_STEP;
          end
        end
        DIV_STEP: begin
          rem    <= sub_ok ? diff : trial[CNT_W-1:0];
          quo    <= {quo[6:0], sub_ok};
          num_lo <= {num_lo[6:0], 1'b0};
          step   <= step + 3'd1;
          if (step == 3'd7) div_state <= DIV_PUB;
        end
        DIV_PUB: div_state <= DIV_IDLE;
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      duty8      <= '0;
      meas_valid <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en)                                  overrun <= 1'b0;
      else if (close && div_state != DIV_IDLE)  overrun <= 1'b1;

      if (en && div_state == DIV_PUB) begin
        high_cnt   <= cap_h;
        period_cnt <= cap_p;
        duty8      <= quo;
        stuck_hi   <= 1'b0;
        stuck_lo   <= 1'b0;
        meas_valid <= 1'b1;
      end else if (to_fire) begin
        high_cnt   <= to_hi ? CNT_MAX : '0;
        period_cnt <= CNT_MAX;
        duty8      <= to_hi ? 8'hFF : 8'h00;
        stuck_hi   <= to_hi;
        stuck_lo   <= ~to_hi;
        meas_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time, period and an 8-bit duty code on the logic analyzer's capture side. It is the receive counterpart to `pwm8`: a waveform from `pwm8` with duty `D`, sampled on the same clock, decodes back to `duty8 = D`. A sequential divider converts raw counts to the duty code. Constant-level inputs are flagged as stuck instead of hanging the block.

## Interface
- `CNT_W`, default 16: width of the high and period counters. Minimum 9.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `pwm_in`, input, 1: asynchronous PWM input.
- `en`, input, 1: measurement enable, level sensitive.
- `high_cnt`, output, `CNT_W`: high cycles of the last period.
- `period_cnt`, output, `CNT_W`: cycles in the last period.
- `duty8`, output, 8: `floor((high_cnt*256 - 1) / period_cnt)`.
- `meas_valid`, output, 1: one-cycle pulse when the outputs update.
- `stuck_hi`, output, 1: the last result was a constant-high timeout.
- `stuck_lo`, output, 1: the last result was a constant-low timeout.
- `overrun`, output, 1: sticky. Set when a period is dropped because the divider was busy.

## Operation
- **Input sync.** `pwm_in` passes through a 2-flop synchronizer to give `s`, then a delay flop gives `s_d`.
  - `rise = s & ~s_d`
  - `fall = ~s & s_d`
- **FSM states:**
  - IDLE: entered on reset or whenever `en=0`, from any state, within one cycle. Counters are cleared.
  - ARM: waits for `rise`.
  - HIGH: counts until `fall`.
  - LOW: counts until `rise`.
- **Counting.**
  - `pcnt` loads 1 on the `rise` cycle, then increments every cycle.
  - `hcnt` loads 1 on the `rise` cycle, then increments while `s=1`.
  - A clean waveform with N sampled-high cycles in a T-cycle period gives `hcnt=N`, `pcnt=T`.
- **Period close.** `rise` in LOW closes the period:
  - If the divider is idle, `hcnt`/`pcnt` are copied into it and an 8-step restoring divide starts.
  - If the divider is busy, the sample is dropped and `overrun` is set.
  - In both cases the counters reload 1 and the FSM goes to HIGH.
- **Divider.**
  - Numerator: `hcnt*256 - 1`, width `CNT_W+8`.
  - Denominator: `pcnt`.
  - One quotient bit per cycle, MSB first. The quotient always fits in 8 bits because `hcnt <= pcnt` and `hcnt >= 1`.
- **Publish.** On divide completion, the outputs register `high_cnt`, `period_cnt` and `duty8`, clear `stuck_hi`/`stuck_lo`, and pulse `meas_valid`. Outputs hold until the next publish.
- **Timeout.** If `pcnt` reaches `2^CNT_W - 1` in HIGH or LOW, the block publishes next cycle, bypassing the divider:
  - from HIGH: `stuck_hi=1`, `duty8=255`, `high_cnt=period_cnt=all ones`;
  - from LOW: `stuck_lo=1`, `duty8=0`, `high_cnt=0`, `period_cnt=all ones`.
  - The FSM then returns to ARM.
- **Partial first period.** ARM plus the first HIGH/LOW after enabling produce no publish. The first valid result needs two rising edges.
- **Simultaneous events.**
  - `en` falling on the same cycle as a closing `rise`: the sample is discarded and an in-flight divide is aborted.
  - A timeout on the same cycle as `rise`: `rise` wins.
- **Overrun clear.** `overrun` clears only on reset or while `en=0`.

## Timing
- **Reset values.** All outputs are 0, the FSM is in IDLE and the divider is idle.
- **Latency.** `pwm_in` first sampled high at edge k gives `rise` in cycle k+1 to k+2. Capture happens at edge k+2, divide steps at edges k+3 to k+10, publish at edge k+11. `meas_valid` is high for the single cycle after edge k+11.
- **Throughput.** Periods shorter than 10 cycles can overrun. Every period of 10 cycles or more publishes.
- **Reset mid-divide.** Clears the divider and outputs immediately, with no publish.

## Test plan
- `pwm8` with `duty=0x80` on a shared `clk`, `en=1` -> from the second rising edge on, each period gives `high_cnt=129`, `period_cnt=256`, `duty8=0x80`, with `meas_valid` exactly every 256 cycles.
- `pwm8` with `duty=0xFF` (constant high), `CNT_W=16` -> one publish with `stuck_hi=1`, `duty8=255`, `period_cnt=0xFFFF`, then a fresh timeout every 65535 cycles. `pwm_in=0` constant -> `stuck_lo=1`, `duty8=0`.
- Synchronous pattern high 3 / low 7 -> `high_cnt=3`, `period_cnt=10`, `duty8=76`, no `overrun`. Latency is exactly 11 edges from the closing high sample to `meas_valid`.
- Pattern high 2 / low 3 (period 5) -> `meas_valid` only for alternating periods, with `duty8=102` (`floor(511/5)`), and `overrun=1` after the first dropped sample.
- `en` deasserted mid-HIGH, then reasserted -> no `meas_valid` until two full rising edges have passed. `overrun` is cleared. Outputs hold their last values.
- `rst_n` pulsed low during a divide step -> all outputs 0 asynchronously, no `meas_valid`, and normal results resume after two rising edges.
